// File: rtl/io_glue.sv
// io_glue: CPU I/O port decoder with clock-enable divider, wait-state FSM and control latch.
// Wait-state insertion (WAIT state, wait counter, waitn) exists only when IO_WAIT_EN is defined.
module io_glue #(
  parameter int         CH       = 4,
  parameter logic [7:0] BASE     = 8'hF8,
  parameter logic [7:0] CTRLPORT = 8'hFF,
  parameter int         CTRLW    = 3,
  parameter int         CTRLLSB  = 3,
  parameter int         DIV      = 5,
  parameter int         CPUK     = 2,
  parameter int         WS       = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            iorq,
  input  logic            rd,
  input  logic            wr,
  input  logic [7:0]      a,
  input  logic [7:0]      q,
  input  logic [8*CH-1:0] extQ,
  input  logic [7:0]      stat,
  output logic [7:0]      d,
  output logic [CH-1:0]   cs,
  output logic            waitn,
  output logic [CTRLW-1:0] ctrl,
  output logic [DIV-2:0]  pe,
  output logic [DIV-2:0]  ne,
  output logic [1:0]      fsm_state
);

`ifdef IO_WAIT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, ACCESS = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd2} state_t;
`endif

  logic [DIV-1:0] ce, ce_nx;
  logic [DIV-2:0] pe_d, ne_d;
  logic           cpuce;

  // pe/ne are registered from the next count so each pulse lines up with the ce value it decodes.
  always_comb begin
    ce_nx = ce + 1'b1;
    pe_d  = '0;
    ne_d  = '0;
    for (int k = 0; k < DIV-1; k++) begin
      pe_d[k] = ce_nx[k+1];
      ne_d[k] = ~ce_nx[k+1];
      for (int j = 0; j <= k; j++) begin
        if (ce_nx[j]) begin
          pe_d[k] = 1'b0;
          ne_d[k] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      ce <= '0;
      pe <= '0;
      ne <= '0;
    end else begin
      ce <= ce_nx;
      pe <= pe_d;
      ne <= ne_d;
    end
  end

  assign cpuce = pe[CPUK];

  logic       ctrl_hit, ch_hit;
  logic [2:0] ch_idx;

  // Decode in 9 bits so BASE+k never wraps past 8'hFF; CTRLPORT masks any overlapping channel.
  always_comb begin
    cs       = '1;
    ch_hit   = 1'b0;
    ch_idx   = 3'd0;
    ctrl_hit = !iorq && (a == CTRLPORT);
    for (int k = 0; k < CH; k++) begin
      if (!iorq && (a != CTRLPORT) && ({1'b0, a} == ({1'b0, BASE} + 9'(k)))) begin
        cs[k]  = 1'b0;
        ch_hit = 1'b1;
        ch_idx = 3'(k);
      end
    end
  end

  state_t     state;
  logic [2:0] sel;
  logic       sel_ctrl;
  logic [7:0] ext_sel;

  always_comb begin
    ext_sel = 8'hFF;
    for (int k = 0; k < CH; k++) begin
      if (sel == 3'(k)) ext_sel = extQ[8*k +: 8];
    end
  end

`ifdef IO_WAIT_EN
  logic [3:0] wcnt;
  logic       waitn_q;
  assign waitn = waitn_q;
`else
  assign waitn = 1'b1;
`endif

  // Handshake: the CPU holds iorq low for the whole access; while waitn is low it must keep
  // a/rd/wr stable, and releasing iorq ends (or aborts) the access on the next cpuce.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= IDLE;
      sel      <= 3'd0;
      sel_ctrl <= 1'b0;
      d        <= 8'hFF;
      ctrl     <= '0;
`ifdef IO_WAIT_EN
      wcnt     <= 4'd0;
      waitn_q  <= 1'b1;
`endif
    end else if (cpuce) begin
      if (!iorq && !wr && (a == CTRLPORT)) ctrl <= q[CTRLLSB +: CTRLW];
      case (state)
        IDLE: begin
          if (ctrl_hit) begin
            state    <= ACCESS;
            sel_ctrl <= 1'b1;
          end else if (ch_hit) begin
            sel      <= ch_idx;
            sel_ctrl <= 1'b0;
`ifdef IO_WAIT_EN
            wcnt     <= 4'(WS);
            if (WS > 0) begin
              state   <= WAIT;
              waitn_q <= 1'b0;
            end else begin
              state   <= ACCESS;
            end
`else
            state    <= ACCESS;
`endif
          end
        end
`ifdef IO_WAIT_EN
        WAIT: begin
          if (iorq) begin
            state   <= IDLE;
            waitn_q <= 1'b1;
            wcnt    <= 4'd0;
          end else if (wcnt <= 4'd1) begin
            state   <= ACCESS;
            waitn_q <= 1'b1;
            wcnt    <= 4'd0;
          end else begin
            wcnt    <= wcnt - 4'd1;
          end
        end
`endif
        ACCESS: begin
          if (iorq) begin
            state <= IDLE;
            d     <= 8'hFF;
          end else if (!rd && wr) begin
            d <= sel_ctrl ? stat : ext_sel;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign fsm_state = state;

  // Only the control field of q is latched; the remaining bits are intentionally ignored.
  logic unused_q;
  assign unused_q = ^q;

endmodule
